muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning iteration count per multiply/divide.
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Start  in  1  EX-stage request, valid one cycle.
REQ-005 SHALL have port Op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 ignored.
REQ-006 SHALL have port A  in  32  rs operand (dividend/multiplicand, MTHI/MTLO source).
REQ-007 SHALL have port B  in  32  rt operand (divisor/multiplier).
REQ-008 SHALL have port HiLoRead  in  1  an MFHI/MFLO is in EX this cycle.
REQ-009 SHALL have port Abort  in  1  pipeline flush; cancels an in-flight operation.
REQ-010 SHALL have port Busy  out  1  iteration in progress.
REQ-011 SHALL have port Stall  out  1  freeze IF/ID/EX this cycle (combinational).
REQ-012 SHALL have port Done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
REQ-013 SHALL have port DivByZero  out  1  one-cycle pulse alongside Done for zero divisor.
REQ-014 SHALL have ports HI and LO  out  32 each  architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIN.
REQ-016 SHALL, in IDLE with Start and Op in 0-3 (nonzero divisor for DIV/DIVU), latch operands, clear counter, and enter RUN.
REQ-017 SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, on unsigned magnitudes.
REQ-018 SHALL go RUN->FIN when counter reaches ITER-1; in FIN it writes HI/LO, pulses Done, and returns to IDLE.
REQ-019 SHALL have latency: Start sampled at edge t0, HI/LO valid and Done high after edge t0+ITER+1; Busy high from edge t0 through t0+ITER+1, exclusive.
REQ-020 SHALL, for signed ops, negate the product if operand signs differ, negate the quotient if signs differ, and give the remainder the dividend's sign.
REQ-021 SHALL return LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF, without an error flag.
REQ-022 SHALL complete DIV/DIVU with B=0 from IDLE in one cycle without entering RUN: HI=A, LO=0xFFFFFFFF, Done and DivByZero pulsed.
REQ-023 SHALL, on MTHI/MTLO in IDLE, write A to HI/LO at the next edge, with no Busy and no Done.
REQ-024 SHALL drive Stall = (Start & Op in 0-3 & B-nonzero-or-multiply & IDLE) | (Busy & (Start | HiLoRead)).
REQ-025 SHALL ignore Start while Busy; the requester holds Start because Stall is asserted.
REQ-026 SHALL, on Abort in RUN or FIN, return to IDLE next edge, leave HI/LO unchanged, and suppress Done; Abort in IDLE has no effect.
REQ-027 SHALL give Abort priority when Abort and the FIN write coincide.
REQ-028 SHALL present HI/LO directly from registers so MFHI/MFLO read them when Stall is low.

Reset
REQ-029 SHALL, on Rst assertion at any time including mid-RUN, force state IDLE, counter 0, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, and drop latched operands.
REQ-030 SHALL not act on Start until the first rising Clk after Rst deasserts.

Structure
REQ-031 SHALL take Op encodings, FSM state encoding, and ITER default from shared package muldiv_pkg.
REQ-032 SHALL use a single combinational sub-module, muldiv_step, for one multiply or divide iteration (accumulator, shifted operand, next counter).
REQ-033 SHALL keep the sign-fix logic and HI/LO registers in muldiv_sequencer.

Verification
REQ-034 SHALL cover MULT A=0xFFFFFFFD, B=7 -> Busy 33 cycles, then Done; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 SHALL cover MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 SHALL cover DIV A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; repeat DIVU 100/0 -> Done+DivByZero next cycle, HI=0x64, LO=0xFFFFFFFF.
REQ-037 SHALL cover HiLoRead asserted at cycle 3 of a DIVU -> Stall high continuously until the Done cycle, low after.
REQ-038 SHALL cover MTLO A=0x1234, then MULT with Abort at RUN cycle 5 -> LO stays 0x1234, no Done.
REQ-039 SHALL cover Rst pulsed at RUN cycle 10 -> HI=LO=0, Busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states, iteration default and magnitude helper
package muldiv_pkg;
  localparam int ITER_DEFAULT = 32;
  typedef enum logic [2:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one unsigned radix-2 multiply or restoring-divide iteration
// Ports: div selects divide; acc is {hi,lo} working register; opnd is multiplicand
// or divisor magnitude; cnt/cnt_next is the iteration counter; acc_next is the result.
module muldiv_step #(
  parameter int CW = 5
) (
  input  logic          div,
  input  logic [63:0]   acc,
  input  logic [31:0]   opnd,
  input  logic [CW-1:0] cnt,
  output logic [63:0]   acc_next,
  output logic [CW-1:0] cnt_next
);
  logic [32:0] sum;
  logic [31:0] diff;
  logic        ge;
  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right.
  // Divide: acc holds {remainder, dividend/quotient bits}, shifted left; the 33-bit
  // shifted remainder is acc[63:31], so its low 32 bits minus opnd is exact when ge.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    ge       = acc[63:31] >= {1'b0, opnd};
    diff     = acc[62:31] - opnd;
    acc_next = div ? {ge ? diff : acc[62:31], acc[30:0], ge} : {sum, acc[31:1]};
    cnt_next = cnt + CW'(1);
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Ports: Clk, Rst (async high); Start/Op/A/B request; HiLoRead marks MFHI/MFLO in EX;
// Abort flushes; Busy, Stall (comb), Done and DivByZero pulses; HI/LO architectural regs.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoRead,
  input  logic        Abort,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [63:0]   acc, acc_next, prod;
  logic [31:0]   opnd, res_hi, res_lo;
  logic          is_div, neg_q, neg_r, is_md, is_dv, sgn, accept;
  always_comb begin
    is_md  = Op < 3'd4;
    is_dv  = Op == OP_DIV || Op == OP_DIVU;
    sgn    = Op == OP_MULT || Op == OP_DIV;
    accept = Start && is_md && (!is_dv || B != '0);
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= S_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = accept ? S_RUN : S_IDLE;
      S_RUN:   state_next = Abort ? S_IDLE : cnt == LAST ? S_FIN : S_RUN;
      default: state_next = S_IDLE;
    endcase
  end
  always_comb begin
    Busy  = state != S_IDLE;
    Stall = (accept && state == S_IDLE) || (Busy && (Start || HiLoRead));
  end
  muldiv_step #(.CW(CW)) u_step (
    .div(is_div), .acc(acc), .opnd(opnd), .cnt(cnt),
    .acc_next(acc_next), .cnt_next(cnt_next)
  );
  // neg_q doubles as the product-negate flag for multiplies
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = is_div ? (neg_r ? -acc[63:32] : acc[63:32]) : prod[63:32];
    res_lo = is_div ? (neg_q ? -acc[31:0] : acc[31:0]) : prod[31:0];
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      if (state == S_IDLE && Start) begin
        if (accept) begin
          acc    <= {32'd0, is_dv ? mag(A, sgn) : mag(B, sgn)};
          opnd   <= is_dv ? mag(B, sgn) : mag(A, sgn);
          is_div <= is_dv;
          neg_q  <= sgn && (A[31] ^ B[31]);
          neg_r  <= sgn && is_dv && A[31];
          cnt    <= '0;
        end else if (is_dv) begin
          HI        <= A;
          LO        <= '1;
          Done      <= 1'b1;
          DivByZero <= 1'b1;
        end else if (Op == OP_MTHI) HI <= A;
        else if (Op == OP_MTLO) LO <= A;
      end else if (state == S_RUN && !Abort) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end else if (state == S_FIN && !Abort) begin
        HI   <= res_hi;
        LO   <= res_lo;
        Done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        Clk, Rst, Start, HiLoRead, Abort;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Stall, Done, DivByZero;
  logic [31:0] HI, LO;
  int cmp = 0;
  int err = 0;
  muldiv_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLoRead(HiLoRead), .Abort(Abort), .Busy(Busy), .Stall(Stall),
    .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    Start = 1'b1; Op = op; A = a; B = b;
    cyc();
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin n++; cyc(); end
  endtask
  task automatic test_reset();
    Rst = 1'b1;
    cyc(); cyc();
    cmp++; if (HI !== 32'h0) begin err++; $display("FAIL reset_hi got %h want %h", HI, 32'h0); end
    cmp++; if (LO !== 32'h0) begin err++; $display("FAIL reset_lo got %h want %h", LO, 32'h0); end
    cmp++; if (Busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", Busy); end
    cmp++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin err++; $display("FAIL reset_done got %b%b want 00", Done, DivByZero); end
    cmp++; if (Stall !== 1'b0) begin err++; $display("FAIL reset_stall got %b want 0", Stall); end
    Rst = 1'b0;
  endtask
  task automatic test_mult();
    int n;
    Start = 1'b1; Op = 3'd0; A = 32'hFFFFFFFD; B = 32'd7;
    #1;
    cmp++; if (Stall !== 1'b1) begin err++; $display("FAIL mult_start_stall got %b want 1", Stall); end
    Start = 1'b0;
    issue(3'd0, 32'hFFFFFFFD, 32'd7, n);
    cmp++; if (n !== 33) begin err++; $display("FAIL mult_busy_cycles got %0d want 33", n); end
    cmp++; if (Done !== 1'b1 || DivByZero !== 1'b0) begin err++; $display("FAIL mult_done got %b%b want 10", Done, DivByZero); end
    cmp++; if (HI !== 32'hFFFFFFFF) begin err++; $display("FAIL mult_hi got %h want %h", HI, 32'hFFFFFFFF); end
    cmp++; if (LO !== 32'hFFFFFFEB) begin err++; $display("FAIL mult_lo got %h want %h", LO, 32'hFFFFFFEB); end
    cyc();
    cmp++; if (Done !== 1'b0) begin err++; $display("FAIL mult_done_pulse got %b want 0", Done); end
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    cmp++; if (HI !== 32'hFFFFFFFE) begin err++; $display("FAIL multu_hi got %h want %h", HI, 32'hFFFFFFFE); end
    cmp++; if (LO !== 32'h00000001) begin err++; $display("FAIL multu_lo got %h want %h", LO, 32'h1); end
  endtask
  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2, n);
    cmp++; if (n !== 33 || Done !== 1'b1) begin err++; $display("FAIL div_timing got n=%0d done=%b want n=33 done=1", n, Done); end
    cmp++; if (LO !== 32'hFFFFFFFD) begin err++; $display("FAIL div_lo got %h want %h", LO, 32'hFFFFFFFD); end
    cmp++; if (HI !== 32'hFFFFFFFF) begin err++; $display("FAIL div_hi got %h want %h", HI, 32'hFFFFFFFF); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    cmp++; if (LO !== 32'h80000000 || HI !== 32'h0) begin err++; $display("FAIL div_ovf got %h:%h want 00000000:80000000", HI, LO); end
    cmp++; if (DivByZero !== 1'b0) begin err++; $display("FAIL div_ovf_flag got %b want 0", DivByZero); end
    issue(3'd3, 32'd100, 32'd7, n);
    cmp++; if (LO !== 32'd14 || HI !== 32'd2) begin err++; $display("FAIL divu got %h:%h want 00000002:0000000e", HI, LO); end
    Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd0;
    #1;
    cmp++; if (Stall !== 1'b0) begin err++; $display("FAIL dz_stall got %b want 0", Stall); end
    cyc();
    Start = 1'b0;
    cmp++; if (Done !== 1'b1 || DivByZero !== 1'b1) begin err++; $display("FAIL dz_flags got %b%b want 11", Done, DivByZero); end
    cmp++; if (Busy !== 1'b0) begin err++; $display("FAIL dz_busy got %b want 0", Busy); end
    cmp++; if (HI !== 32'h64 || LO !== 32'hFFFFFFFF) begin err++; $display("FAIL dz_hilo got %h:%h want 00000064:ffffffff", HI, LO); end
    cyc();
    cmp++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin err++; $display("FAIL dz_pulse got %b%b want 00", Done, DivByZero); end
  endtask
  task automatic test_mtlo_abort();
    int n;
    bit seen;
    Start = 1'b1; Op = 3'd5; A = 32'h1234;
    #1;
    cmp++; if (Stall !== 1'b0) begin err++; $display("FAIL mtlo_stall got %b want 0", Stall); end
    cyc();
    Start = 1'b0;
    cmp++; if (LO !== 32'h1234 || Busy !== 1'b0 || Done !== 1'b0) begin err++; $display("FAIL mtlo got lo=%h busy=%b done=%b want 00001234 0 0", LO, Busy, Done); end
    Start = 1'b1; Op = 3'd4; A = 32'hABCD;
    cyc();
    Start = 1'b0;
    cmp++; if (HI !== 32'hABCD || Done !== 1'b0) begin err++; $display("FAIL mthi got hi=%h done=%b want 0000abcd 0", HI, Done); end
    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6;
    cyc();
    Start = 1'b0;
    repeat (4) cyc();
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    cmp++; if (Busy !== 1'b0) begin err++; $display("FAIL abort_run_busy got %b want 0", Busy); end
    seen = 1'b0;
    repeat (40) begin if (Done) seen = 1'b1; cyc(); end
    cmp++; if (seen !== 1'b0) begin err++; $display("FAIL abort_run_done got %b want 0", seen); end
    cmp++; if (LO !== 32'h1234 || HI !== 32'hABCD) begin err++; $display("FAIL abort_run_hilo got %h:%h want 0000abcd:00001234", HI, LO); end
    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6;
    cyc();
    Start = 1'b0;
    repeat (32) cyc();
    cmp++; if (Busy !== 1'b1) begin err++; $display("FAIL fin_busy got %b want 1", Busy); end
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    cmp++; if (Busy !== 1'b0 || Done !== 1'b0) begin err++; $display("FAIL abort_fin got busy=%b done=%b want 0 0", Busy, Done); end
    cmp++; if (LO !== 32'h1234 || HI !== 32'hABCD) begin err++; $display("FAIL abort_fin_hilo got %h:%h want 0000abcd:00001234", HI, LO); end
    issue(3'd0, 32'd5, 32'd6, n);
    cmp++; if (HI !== 32'h0 || LO !== 32'd30 || Done !== 1'b1) begin err++; $display("FAIL post_abort got %h:%h done=%b want 00000000:0000001e 1", HI, LO, Done); end
  endtask
  task automatic test_stall_hilo();
    int n, bad;
    Start = 1'b1; Op = 3'd3; A = 32'd1000; B = 32'd10;
    cyc();
    Start = 1'b0;
    cyc();
    cmp++; if (Stall !== 1'b0) begin err++; $display("FAIL idle_read_stall got %b want 0", Stall); end
    cyc();
    HiLoRead = 1'b1;
    #1;
    n = 0; bad = 0;
    while (Busy && n < 100) begin if (Stall !== 1'b1) bad++; n++; cyc(); end
    cmp++; if (bad !== 0 || n !== 31) begin err++; $display("FAIL hilo_stall got bad=%0d n=%0d want bad=0 n=31", bad, n); end
    cmp++; if (Stall !== 1'b0 || Done !== 1'b1) begin err++; $display("FAIL hilo_release got stall=%b done=%b want 0 1", Stall, Done); end
    cmp++; if (LO !== 32'd100 || HI !== 32'd0) begin err++; $display("FAIL hilo_divu got %h:%h want 00000000:00000064", HI, LO); end
    HiLoRead = 1'b0;
  endtask
  task automatic test_back_to_back();
    int n, bad;
    Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd4;
    cyc();
    Op = 3'd0; A = 32'hFFFFFFFE; B = 32'd3;
    #1;
    n = 0; bad = 0;
    while (Busy && n < 100) begin if (Stall !== 1'b1) bad++; n++; cyc(); end
    cmp++; if (bad !== 0 || n !== 33) begin err++; $display("FAIL b2b_first got bad=%0d n=%0d want bad=0 n=33", bad, n); end
    cmp++; if (HI !== 32'h0 || LO !== 32'd12 || Done !== 1'b1) begin err++; $display("FAIL b2b_first_res got %h:%h done=%b want 00000000:0000000c 1", HI, LO, Done); end
    cmp++; if (Stall !== 1'b1) begin err++; $display("FAIL b2b_idle_stall got %b want 1", Stall); end
    cyc();
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin n++; cyc(); end
    cmp++; if (n !== 33 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin err++; $display("FAIL b2b_second got n=%0d %h:%h want n=33 ffffffff:fffffffa", n, HI, LO); end
  endtask
  task automatic test_reset_midrun();
    Start = 1'b1; Op = 3'd0; A = 32'hFFFFFFFD; B = 32'd7;
    cyc();
    Start = 1'b0;
    repeat (9) cyc();
    #2;
    Rst = 1'b1;
    Start = 1'b1; Op = 3'd5; A = 32'h55;
    #1;
    cmp++; if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin err++; $display("FAIL async_reset got busy=%b %h:%h want 0 00000000:00000000", Busy, HI, LO); end
    cmp++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin err++; $display("FAIL async_reset_flags got %b%b want 00", Done, DivByZero); end
    cyc();
    Rst = 1'b0;
    #1;
    cmp++; if (LO !== 32'h0) begin err++; $display("FAIL start_in_reset got %h want 00000000", LO); end
    cyc();
    Start = 1'b0;
    cmp++; if (LO !== 32'h55) begin err++; $display("FAIL start_after_reset got %h want 00000055", LO); end
  endtask
  initial begin
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0; HiLoRead = 1'b0; Abort = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mtlo_abort();
    test_stall_hilo();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
